instr_prefetch_buffer: RTL and testbench



---
 rtl/instr_prefetch_buffer.sv | 159 +++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: in-order instruction prefetcher feeding IF/ID from a DEPTH-entry {pc, instr} FIFO.
// Latency: request accepted in cycle N, response in N+L, out_valid in N+L+1 (head is registered, no resp->out path).
// Backpressure: fetch is credit-limited (FIFO occupancy + outstanding < DEPTH); out_ready low only holds the head.
// Ports: clk, rst (synchronous, active-high); redirect_valid/redirect_pc flush the buffer and restart fetch;
//        imem_req_valid/imem_req_addr/imem_req_ready request channel; imem_resp_valid/imem_resp_data in-order
//        responses; out_valid/out_pc/out_instr/out_ready towards IF/ID.
// Optional: define PREFETCH_ERR_EN to add imem_resp_err/out_err; an error entry halts fetch until a redirect.
module instr_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
`ifdef PREFETCH_ERR_EN
    input  logic        imem_resp_err,
    output logic        out_err,
`endif
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, STALL, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            stop_q, stop_d;
    logic [31:0]     pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];

    logic            redir, accept, resp_cnt, push, pop, credit_ok, credit_nxt;
    logic [31:0]     redir_pc;

    // Redirects are meaningless before fetch has started.
    assign redir    = redirect_valid && (state_q != IDLE);
    assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

    assign credit_ok      = ({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_C;
    assign imem_req_valid = (state_q == FETCH) && credit_ok && !stop_q;
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is ignored so the counter cannot underflow.
    assign resp_cnt = imem_resp_valid && (outstanding_q != '0);
    assign push     = resp_cnt && (state_q != FLUSH) && !redir;
    assign pop      = out_valid && out_ready;

    assign out_valid = (count_q != '0);
    assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : 32'h0;
    assign out_instr = out_valid ? instr_mem[rd_ptr_q] : 32'h0;

    // Occupancy, pointers and outstanding count for the next cycle.
    always_comb begin
        outstanding_d = outstanding_q + CW'(accept) - CW'(resp_cnt);
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        if (redir) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    assign credit_nxt = ({1'b0, count_d} + {1'b0, outstanding_d}) < DEPTH_C;

    // Next-state logic. Fetch is strictly sequential between redirects, so the in-order
    // PC tag queue reduces to a running pointer (resp_pc) for the next kept response.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
        if (push)   resp_pc_d  = resp_pc_q + 32'd4;
        if ((state_q == FLUSH) && resp_cnt) drop_cnt_d = drop_cnt_q - CW'(1);
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (!credit_nxt || stop_d) state_d = STALL;
            STALL:   if (credit_nxt && !stop_d) state_d = FETCH;
            FLUSH:   if (drop_cnt_d == '0) state_d = FETCH;
            default: state_d = IDLE;
        endcase
        // Everything still in flight after this cycle belongs to the old stream.
        if (redir) begin
            fetch_pc_d = redir_pc;
            resp_pc_d  = redir_pc;
            drop_cnt_d = outstanding_d;
            state_d    = (outstanding_d != '0) ? FLUSH : FETCH;
        end
    end

`ifdef PREFETCH_ERR_EN
    logic err_mem [DEPTH];

    assign stop_d  = redir ? 1'b0 : (stop_q || (push && imem_resp_err));
    assign out_err = out_valid ? err_mem[rd_ptr_q] : 1'b0;

    always_ff @(posedge clk) begin
        if (push) err_mem[wr_ptr_q] <= imem_resp_err;
    end
`else
    assign stop_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            stop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            stop_q        <= stop_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= resp_pc_q;
            instr_mem[wr_ptr_q] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Testbench for instr_prefetch_buffer: directed scenarios against a behavioural in-order memory.
// Memory returns 32'hCAFE_0000 | addr[15:0] for every word, with a programmable latency.
module tb_instr_prefetch_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
`ifdef PREFETCH_ERR_EN
    logic        imem_resp_err = 1'b0;
    logic        out_err;
`endif
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b1;

    int          total = 0;
    int          bad = 0;
    int          lat = 1;
    int          cyc = 0;
    logic [31:0] err_addr = 32'h1;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] acc_q[$];
    logic [31:0] opc_q[$];
    logic [31:0] oin_q[$];
    logic [31:0] oerr_q[$];

    always #5 clk = ~clk;

    instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
`ifdef PREFETCH_ERR_EN
        .imem_resp_err   (imem_resp_err),
        .out_err         (out_err),
`endif
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .out_ready       (out_ready)
    );

    // In-order memory: a request accepted in cycle N answers in cycle N+lat.
    always begin
        @(posedge clk);
        if (rst) begin
            mq_addr.delete();
            mq_due.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + lat);
        end
        cyc++;
        #1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
`ifdef PREFETCH_ERR_EN
        imem_resp_err   = 1'b0;
`endif
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hCAFE_0000 | {16'h0000, mq_addr[0][15:0]};
`ifdef PREFETCH_ERR_EN
            imem_resp_err   = (mq_addr[0] == err_addr);
`endif
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        acc_q.delete();
        opc_q.delete();
        oin_q.delete();
        oerr_q.delete();
    endtask

    // Log request and output handshakes for n cycles.
    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            if (imem_req_valid && imem_req_ready) acc_q.push_back(imem_req_addr);
            if (out_valid && out_ready) begin
                opc_q.push_back(out_pc);
                oin_q.push_back(out_instr);
`ifdef PREFETCH_ERR_EN
                oerr_q.push_back({31'h0, out_err});
`else
                oerr_q.push_back(32'h0);
`endif
            end
            tick();
        end
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int k);
        return (q.size() > k) ? q[k] : 32'hDEAD_DEAD;
    endfunction

    initial begin
        // Reset state and first-word latency (latency 1, always ready).
        tick();
        tick();
        check32("rst_req_vld", {31'h0, imem_req_valid}, 32'd0);
        check32("rst_out_vld", {31'h0, out_valid}, 32'd0);
        check32("rst_out_pc", out_pc, 32'h0);
        check32("rst_out_instr", out_instr, 32'h0);
        rst = 1'b0;
        check32("idle_req_vld", {31'h0, imem_req_valid}, 32'd0);
        tick();
        check32("first_req_vld", {31'h0, imem_req_valid}, 32'd1);
        check32("first_req_addr", imem_req_addr, 32'h0);
        tick();
        check32("second_req_addr", imem_req_addr, 32'h4);
        check32("early_out_vld", {31'h0, out_valid}, 32'd0);
        tick();
        check32("first_out_vld", {31'h0, out_valid}, 32'd1);
        check32("first_out_pc", out_pc, 32'h0);
        check32("first_out_instr", out_instr, 32'hCAFE_0000);
        clear_logs();
        collect(4);
        check32("stream_cnt", opc_q.size(), 32'd4);
        check32("stream_pc1", at(opc_q, 1), 32'h4);
        check32("stream_pc2", at(opc_q, 2), 32'h8);
        check32("stream_pc3", at(opc_q, 3), 32'hC);
        check32("stream_in3", at(oin_q, 3), 32'hCAFE_000C);

        // Output blocked: credits cap fetch at DEPTH requests.
        rst = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
        collect(20);
        check32("full_acc_cnt", acc_q.size(), 32'd4);
        check32("full_acc_last", at(acc_q, 3), 32'hC);
        check32("full_req_vld", {31'h0, imem_req_valid}, 32'd0);
        check32("full_out_vld", {31'h0, out_valid}, 32'd1);
        check32("full_head_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        clear_logs();
        collect(8);
        check32("drain_pc0", at(opc_q, 0), 32'h0);
        check32("drain_pc1", at(opc_q, 1), 32'h4);
        check32("drain_pc2", at(opc_q, 2), 32'h8);
        check32("drain_pc3", at(opc_q, 3), 32'hC);
        check32("drain_pc4", at(opc_q, 4), 32'h10);
        check32("resume_addr", at(acc_q, 0), 32'h10);

        // Latency 3, three outstanding, redirect to 0x100 (one response lands on the redirect cycle).
        imem_req_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        lat = 3;
        imem_req_ready = 1'b1;
        tick();
        tick();
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check32("flush_out_vld", {31'h0, out_valid}, 32'd0);
        check32("flush_req_vld0", {31'h0, imem_req_valid}, 32'd0);
        imem_req_ready = 1'b1;
        tick();
        check32("flush_req_vld1", {31'h0, imem_req_valid}, 32'd0);
        tick();
        check32("post_flush_vld", {31'h0, imem_req_valid}, 32'd1);
        check32("post_flush_addr", imem_req_addr, 32'h100);
        clear_logs();
        collect(8);
        check32("redir_acc0", at(acc_q, 0), 32'h100);
        check32("redir_pc0", at(opc_q, 0), 32'h100);
        check32("redir_in0", at(oin_q, 0), 32'hCAFE_0100);

        // Redirect together with an acceptance and a pop, one outstanding: two drops.
        imem_req_ready = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        out_ready = 1'b0;
        lat = 2;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        tick();
        tick();
        check32("hold_out_vld", {31'h0, out_valid}, 32'd1);
        imem_req_ready = 1'b1;
        tick();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        check32("drop2_out_vld", {31'h0, out_valid}, 32'd0);
        check32("drop2_req_vld0", {31'h0, imem_req_valid}, 32'd0);
        tick();
        check32("drop2_req_vld1", {31'h0, imem_req_valid}, 32'd0);
        tick();
        check32("drop2_resume_vld", {31'h0, imem_req_valid}, 32'd1);
        check32("drop2_resume_addr", imem_req_addr, 32'h200);
        clear_logs();
        collect(8);
        check32("drop2_pc0", at(opc_q, 0), 32'h200);

        // Redirect near the top of the address space; low bits of redirect_pc ignored.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        check32("wrap_out_vld", {31'h0, out_valid}, 32'd0);
        clear_logs();
        collect(10);
        check32("wrap_acc0", at(acc_q, 0), 32'hFFFF_FFFC);
        check32("wrap_acc1", at(acc_q, 1), 32'h0);
        check32("wrap_pc0", at(opc_q, 0), 32'hFFFF_FFFC);
        check32("wrap_pc1", at(opc_q, 1), 32'h0);
        check32("wrap_in0", at(oin_q, 0), 32'hCAFE_FFFC);

`ifdef PREFETCH_ERR_EN
        // Error response at 0x8 halts fetch until a redirect.
        rst = 1'b1;
        lat = 1;
        tick();
        tick();
        check32("err_rst_out_err", {31'h0, out_err}, 32'd0);
        err_addr = 32'h8;
        rst = 1'b0;
        clear_logs();
        collect(12);
        check32("err_pc2", at(opc_q, 2), 32'h8);
        check32("err_flag2", at(oerr_q, 2), 32'd1);
        check32("err_flag1", at(oerr_q, 1), 32'd0);
        check32("err_acc_cnt", acc_q.size(), 32'd4);
        check32("err_req_vld", {31'h0, imem_req_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        clear_logs();
        collect(8);
        check32("err_redir_acc0", at(acc_q, 0), 32'h40);
        check32("err_redir_pc0", at(opc_q, 0), 32'h40);
        check32("err_redir_flag0", at(oerr_q, 0), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
